// File: rtl/vertex_frame_tx.sv
// Streams one response frame (header, gyro sample, vertex count, vertex coordinates) to a UART byte port.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte covering everything after the header.
module vertex_frame_tx #(
  parameter int MAX_VERTICES = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        gyro_x,
  input  logic [15:0]        gyro_y,
  input  logic [15:0]        gyro_z,
  input  logic [7:0]         vertex_count,
  output logic               rd_en,
  output logic [7:0]         rd_vertex,
  output logic [1:0]         rd_coord,
  input  logic signed [31:0] rd_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done,
  output logic [3:0]         dbg_state
);

  // Byte handshake: a byte moves on a cycle where tx_valid and tx_ready are both high;
  // once tx_valid rises, it and tx_data hold until that transfer happens.
  typedef enum logic [3:0] {
    IDLE, HDR, GYRO, COUNT, FETCH, WAIT_RD, VERT, FIN
`ifdef FRAME_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  localparam logic [7:0] MAX_N = 8'(MAX_VERTICES);

  state_t      state;
  logic [47:0] gyro_q;
  logic [7:0]  n_q;
  logic [2:0]  gyro_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word_q;
  logic        xfer;
  logic        last_word;

  assign xfer      = tx_valid & tx_ready;
  assign last_word = (rd_vertex == n_q - 8'd1) && (rd_coord == 2'd2);
  assign dbg_state = state;

  function automatic logic [7:0] gyro_byte(input logic [47:0] g, input logic [2:0] idx);
    case (idx)
      3'd0:    return g[47:40];
      3'd1:    return g[39:32];
      3'd2:    return g[31:24];
      3'd3:    return g[23:16];
      3'd4:    return g[15:8];
      default: return g[7:0];
    endcase
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 8'd0;
    end else if (state == IDLE && start) begin
      csum_q <= 8'd0;
    end else if (xfer && (state == GYRO || state == COUNT || state == VERT)) begin
      csum_q <= csum_q ^ tx_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gyro_q    <= 48'd0;
      n_q       <= 8'd0;
      gyro_idx  <= 3'd0;
      byte_idx  <= 2'd0;
      word_q    <= 32'd0;
      rd_en     <= 1'b0;
      rd_vertex <= 8'd0;
      rd_coord  <= 2'd0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          gyro_q    <= {gyro_x, gyro_y, gyro_z};
          n_q       <= (vertex_count > MAX_N) ? MAX_N : vertex_count;
          gyro_idx  <= 3'd0;
          rd_vertex <= 8'd0;
          rd_coord  <= 2'd0;
          tx_data   <= 8'hCC;
          tx_valid  <= 1'b1;
          busy      <= 1'b1;
          state     <= HDR;
        end
        HDR: if (xfer) begin
          tx_data <= gyro_byte(gyro_q, 3'd0);
          state   <= GYRO;
        end
        GYRO: if (xfer) begin
          if (gyro_idx == 3'd5) begin
            tx_data <= n_q;
            state   <= COUNT;
          end else begin
            gyro_idx <= gyro_idx + 3'd1;
            tx_data  <= gyro_byte(gyro_q, gyro_idx + 3'd1);
          end
        end
        COUNT: if (xfer) begin
          if (n_q != 8'd0) begin
            tx_valid  <= 1'b0;
            rd_en     <= 1'b1;
            rd_vertex <= 8'd0;
            rd_coord  <= 2'd0;
            state     <= FETCH;
          end else begin
`ifdef FRAME_CHECKSUM_EN
            tx_data <= csum_q ^ tx_data;
            state   <= CSUM;
`else
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
`endif
          end
        end
        FETCH: state <= WAIT_RD;
        WAIT_RD: begin
          word_q   <= rd_data;
          tx_data  <= rd_data[7:0];
          tx_valid <= 1'b1;
          byte_idx <= 2'd0;
          state    <= VERT;
        end
        VERT: if (xfer) begin
          if (byte_idx != 2'd3) begin
            byte_idx <= byte_idx + 2'd1;
            tx_data  <= word_byte(word_q, byte_idx + 2'd1);
          end else if (last_word) begin
`ifdef FRAME_CHECKSUM_EN
            tx_data <= csum_q ^ tx_data;
            state   <= CSUM;
`else
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
`endif
          end else begin
            // Address advances here so it stays put from FETCH to the last byte of the word.
            if (rd_coord == 2'd2) begin
              rd_coord  <= 2'd0;
              rd_vertex <= rd_vertex + 8'd1;
            end else begin
              rd_coord <= rd_coord + 2'd1;
            end
            tx_valid <= 1'b0;
            rd_en    <= 1'b1;
            state    <= FETCH;
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CSUM: if (xfer) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
          state    <= FIN;
        end
`endif
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
